// File: rtl/vram_pkg.sv
// Shared constants and phase encoding for the text-mode video RAM arbiter.
// One 25 MHz pixel period is split into four 100 MHz phases.
package vram_pkg;

    localparam int VRAM_ADDR_W = 12;
    localparam int VRAM_DATA_W = 8;
    localparam int TEXT_COLS   = 80;
    localparam int TEXT_ROWS   = 25;

    // Video address goes out in phase 0, RAM reads it in phase 1,
    // CPU address goes out in phase 2, RAM performs the CPU op in phase 3.
    typedef enum logic [1:0] {
        PH_VID_ADDR = 2'd0,
        PH_VID_RAM  = 2'd1,
        PH_CPU_ADDR = 2'd2,
        PH_CPU_RAM  = 2'd3
    } phase_t;

    function automatic phase_t next_phase(input phase_t p);
        case (p)
            PH_VID_ADDR: next_phase = PH_VID_RAM;
            PH_VID_RAM:  next_phase = PH_CPU_ADDR;
            PH_CPU_ADDR: next_phase = PH_CPU_RAM;
            default:     next_phase = PH_VID_ADDR;
        endcase
    endfunction

endpackage

// File: rtl/vram_arbiter_if.sv
// CPU access port of the video RAM arbiter, bundled as an interface.
interface vram_arbiter_if
    import vram_pkg::*;
#(
    parameter int ADDR_W = VRAM_ADDR_W,
    parameter int DATA_W = VRAM_DATA_W
);
    // Handshake: cpu_req is a one-cycle strobe, taken only on an edge where
    // cpu_ready=1; we/addr/wdata are sampled with it. Completion is a single
    // cpu_ack cycle, and cpu_rdata holds the read result until the next ack.
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ready;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ready, cpu_ack, cpu_rdata
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ready, cpu_ack, cpu_rdata
    );

endinterface

// File: rtl/vram_arbiter.sv
// Time-slot arbiter sharing a single-port text VRAM between the video fetch
// (fixed slot) and one outstanding CPU access; also makes the 25 MHz enable.
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int ADDR_W = VRAM_ADDR_W,
    parameter int DATA_W = VRAM_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    output logic              vid_ce,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic [DATA_W-1:0] vid_rdata,
    vram_arbiter_if.slave     cpu,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output phase_t            dbg_phase,
    output logic              dbg_busy
);

    phase_t            phase_q;
    phase_t            phase_d;
    logic              busy;
    logic              issued;
    logic              cpu_we_l;
    logic [ADDR_W-1:0] cpu_addr_l;
    logic [DATA_W-1:0] cpu_wdata_l;
    logic              ack_q;
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= PH_VID_ADDR;
        end else begin
            phase_q <= phase_d;
        end
    end

    always_comb begin
        phase_d = phase_q;
        phase_d = next_phase(phase_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vid_ce      <= 1'b0;
            vid_rdata   <= '0;
            mem_addr    <= '0;
            mem_we      <= 1'b0;
            mem_wdata   <= '0;
            busy        <= 1'b0;
            issued      <= 1'b0;
            cpu_we_l    <= 1'b0;
            cpu_addr_l  <= '0;
            cpu_wdata_l <= '0;
            ack_q       <= 1'b0;
            rdata_q     <= '0;
        end else begin
            vid_ce <= (phase_q == PH_CPU_ADDR);
            ack_q  <= 1'b0;

            if (cpu.cpu_req && !busy) begin
                cpu_we_l    <= cpu.cpu_we;
                cpu_addr_l  <= cpu.cpu_addr;
                cpu_wdata_l <= cpu.cpu_wdata;
                busy        <= 1'b1;
            end

            case (phase_q)
                PH_VID_ADDR: begin
                    mem_addr <= vid_addr;
                    mem_we   <= 1'b0;
                    // RAM returned the phase-3 CPU result during this phase.
                    if (issued) begin
                        if (!cpu_we_l) begin
                            rdata_q <= mem_rdata;
                        end
                        ack_q  <= 1'b1;
                        busy   <= 1'b0;
                        issued <= 1'b0;
                    end
                end
                PH_CPU_ADDR: begin
                    vid_rdata <= mem_rdata;
                    // busy here is the pre-edge value, so a request landing
                    // on this very edge waits a full period for its slot.
                    if (busy && !issued) begin
                        mem_addr  <= cpu_addr_l;
                        mem_we    <= cpu_we_l;
                        mem_wdata <= cpu_wdata_l;
                        issued    <= 1'b1;
                    end
                end
                PH_CPU_RAM: begin
                    mem_we <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    assign cpu.cpu_ready = !busy && !rst;
    assign cpu.cpu_ack   = ack_q;
    assign cpu.cpu_rdata = rdata_q;
    assign dbg_phase     = phase_q;
    assign dbg_busy      = busy;

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: RAM model, slot monitor, CPU ack scoreboard and
// video fetch scoreboard, driven from one directed sequence.
module tb_vram_arbiter;
    import vram_pkg::*;

    localparam int AW = 12;
    localparam int DW = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          vid_ce;
    logic [AW-1:0] vid_addr = '0;
    logic [DW-1:0] vid_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    phase_t        dbg_phase;
    logic          dbg_busy;

    vram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) cpu_bus ();

    vram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .vid_ce    (vid_ce),
        .vid_addr  (vid_addr),
        .vid_rdata (vid_rdata),
        .cpu       (cpu_bus.slave),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .dbg_phase (dbg_phase),
        .dbg_busy  (dbg_busy)
    );

    // Synchronous single-port RAM, data valid the cycle after the address.
    logic [DW-1:0] ram     [4096];
    logic [DW-1:0] ref_mem [4096];
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    // Reference phase and cycle count, independent of the DUT.
    int         cyc = 0;
    logic [1:0] mp  = 2'd0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        mp  <= rst ? 2'd0 : mp + 2'd1;
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // ---------------- scoreboard ----------------
    logic [DW-1:0] exp_q[$];
    int            exp_cyc_q[$];
    logic [DW-1:0] vid_q[$];

    logic          mon_en      = 1'b0;
    logic          vid_en      = 1'b0;
    logic          vid_stream  = 1'b0;
    logic [AW-1:0] vid_next    = '0;
    logic [AW-1:0] vid_a       = '0;
    logic [3:0]    vid_ctr     = '0;
    logic [AW-1:0] exp_wr_addr = '0;
    logic [DW-1:0] last_rdata  = '0;

    always @(posedge clk) begin
        #1;
        if (mon_en) begin
            check("vid_ce", {31'd0, vid_ce}, {31'd0, mp == 2'd3});
            check("phase", {30'd0, dbg_phase}, {30'd0, mp});
            if (mem_we) begin
                check("we_slot", {30'd0, mp}, 32'd3);
                check("we_addr", {20'd0, mem_addr}, {20'd0, exp_wr_addr});
            end
            if (cpu_bus.cpu_ack) begin
                if (exp_q.size() == 0) begin
                    check("spurious_ack", {31'd0, cpu_bus.cpu_ack}, 32'd0);
                end else begin
                    check("ack_cycle", cyc, exp_cyc_q.pop_front());
                    check("cpu_rdata", {24'd0, cpu_bus.cpu_rdata}, {24'd0, exp_q.pop_front()});
                    check("ready_at_ack", {31'd0, cpu_bus.cpu_ready}, 32'd1);
                    check("ack_phase", {30'd0, mp}, 32'd1);
                end
            end
            if (mp == 2'd3 && vid_q.size() > 0)
                check("vid_rdata", {24'd0, vid_rdata}, {24'd0, vid_q.pop_front()});
            if (mp == 2'd0 && vid_en && !rst) begin
                vid_a = vid_stream ? {8'd0, vid_ctr} : vid_next;
                vid_ctr++;
                vid_addr = vid_a;
                vid_q.push_back(ref_mem[vid_a]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_phase(input logic [1:0] p);
        for (int i = 0; i < 4 && mp != p; i++) tick();
        check("wait_phase", {30'd0, mp}, {30'd0, p});
    endtask

    task automatic cpu_op(input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, input logic [DW-1:0] exp_rd,
                          input bit track);
        int lat;
        case (mp)
            2'd0:    lat = 5;
            2'd1:    lat = 4;
            2'd2:    lat = 7;
            default: lat = 6;
        endcase
        check("ready_before_req", {31'd0, cpu_bus.cpu_ready}, 32'd1);
        cpu_bus.cpu_req   = 1'b1;
        cpu_bus.cpu_we    = we;
        cpu_bus.cpu_addr  = addr;
        cpu_bus.cpu_wdata = wdata;
        if (track) begin
            exp_q.push_back(exp_rd);
            exp_cyc_q.push_back(cyc + lat);
        end
        tick();
        cpu_bus.cpu_req = 1'b0;
    endtask

    task automatic wait_ack();
        for (int i = 0; i < 16 && exp_q.size() > 0; i++) tick();
        check("ack_timeout", exp_q.size(), 32'd0);
        if (exp_q.size() > 0) begin
            exp_q.delete();
            exp_cyc_q.delete();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- sequence ----------------
    initial begin
        for (int i = 0; i < 4096; i++) ram[i] = i[7:0] ^ 8'h5C;
        ram[12'h0A0] = 8'h41;
        ram[12'h7FF] = 8'hC3;
        for (int i = 0; i < 4096; i++) ref_mem[i] = ram[i];
        cpu_bus.cpu_req   = 1'b0;
        cpu_bus.cpu_we    = 1'b0;
        cpu_bus.cpu_addr  = '0;
        cpu_bus.cpu_wdata = '0;

        rst = 1'b1;
        repeat (3) tick();
        check("rst_vid_ce", {31'd0, vid_ce}, 32'd0);
        check("rst_ready", {31'd0, cpu_bus.cpu_ready}, 32'd0);
        check("rst_ack", {31'd0, cpu_bus.cpu_ack}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_mem_addr", {20'd0, mem_addr}, 32'd0);
        check("rst_mem_wdata", {24'd0, mem_wdata}, 32'd0);
        check("rst_vid_rdata", {24'd0, vid_rdata}, 32'd0);
        check("rst_cpu_rdata", {24'd0, cpu_bus.cpu_rdata}, 32'd0);
        check("rst_busy", {31'd0, dbg_busy}, 32'd0);
        check("rst_phase", {30'd0, dbg_phase}, 32'd0);
        rst    = 1'b0;
        mon_en = 1'b1;

        // Idle: slots keep turning, no CPU activity.
        for (int i = 0; i < 8; i++) begin
            tick();
            check("idle_ready", {31'd0, cpu_bus.cpu_ready}, 32'd1);
            check("idle_ack", {31'd0, cpu_bus.cpu_ack}, 32'd0);
        end

        // Video fetch of a preloaded character.
        vid_next = 12'h0A0;
        vid_en   = 1'b1;
        repeat (8) tick();
        wait_phase(2'd3);
        check("vid_0a0", {24'd0, vid_rdata}, 32'h41);

        // CPU write accepted in phase 1, then read back through the video slot.
        exp_wr_addr = 12'h123;
        wait_phase(2'd1);
        cpu_op(1'b1, 12'h123, 8'h5A, last_rdata, 1'b1);
        wait_ack();
        ref_mem[12'h123] = 8'h5A;
        vid_next = 12'h123;
        repeat (8) tick();
        wait_phase(2'd3);
        check("vid_123", {24'd0, vid_rdata}, 32'h5A);

        // CPU read accepted in phase 2 while video streams 0x000..0x00F.
        vid_stream = 1'b1;
        wait_phase(2'd2);
        cpu_op(1'b0, 12'h7FF, 8'h00, 8'hC3, 1'b1);
        wait_ack();
        last_rdata = 8'hC3;
        repeat (20) tick();
        vid_stream = 1'b0;

        // Back-to-back: request while busy is dropped, request in the ack cycle is taken.
        exp_wr_addr = 12'h300;
        wait_phase(2'd1);
        cpu_op(1'b0, 12'h0A0, 8'h00, 8'h41, 1'b1);
        check("busy_ready", {31'd0, cpu_bus.cpu_ready}, 32'd0);
        cpu_bus.cpu_req   = 1'b1;
        cpu_bus.cpu_we    = 1'b1;
        cpu_bus.cpu_addr  = 12'h7FF;
        cpu_bus.cpu_wdata = 8'h99;
        tick();
        cpu_bus.cpu_req = 1'b0;
        for (int i = 0; i < 12 && !cpu_bus.cpu_ack; i++) tick();
        check("ack_seen", {31'd0, cpu_bus.cpu_ack}, 32'd1);
        cpu_op(1'b1, 12'h300, 8'h77, 8'h41, 1'b1);
        wait_ack();
        last_rdata = 8'h41;
        ref_mem[12'h300] = 8'h77;
        vid_next = 12'h300;
        repeat (12) tick();

        // Reset during phase 3 of a pending write: no ack, slots restart.
        vid_en      = 1'b0;
        exp_wr_addr = 12'h200;
        wait_phase(2'd1);
        cpu_op(1'b1, 12'h200, 8'hEE, 8'h00, 1'b0);
        wait_phase(2'd3);
        check("rst_pre_we", {31'd0, mem_we}, 32'd1);
        rst = 1'b1;
        tick();
        vid_q.delete();
        check("mid_rst_we", {31'd0, mem_we}, 32'd0);
        check("mid_rst_busy", {31'd0, dbg_busy}, 32'd0);
        check("mid_rst_phase", {30'd0, dbg_phase}, 32'd0);
        check("mid_rst_ack", {31'd0, cpu_bus.cpu_ack}, 32'd0);
        check("mid_rst_ready", {31'd0, cpu_bus.cpu_ready}, 32'd0);
        rst = 1'b0;
        repeat (12) tick();
        check("post_rst_ready", {31'd0, cpu_bus.cpu_ready}, 32'd1);
        check("post_rst_busy", {31'd0, dbg_busy}, 32'd0);

        check("acks_outstanding", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
Time-slot arbiter for the single-port 4 KB text video RAM (char/attr pairs, 80x25). It shares the RAM between the text adapter's fixed-rate fetch and a CPU read/write port. Runs on the 100 MHz system clock. It divides each 25 MHz pixel period into 4 phases: a guaranteed video read slot and a CPU slot. It also generates the 25 MHz clock-enable that the adapter uses instead of a divided clock.

Parameters:
ADDR_W, 12, video RAM address width (4096 bytes)
DATA_W, 8, video RAM data width

Ports:
clk  in  1  100 MHz system clock
rst  in  1  reset; synchronous to clk, active-high
vid_ce  out  1  25 MHz clock-enable to the adapter; high during phase 3 only
vid_addr  in  ADDR_W  adapter fetch address; changes only on edges where vid_ce=1
vid_rdata  out  DATA_W  byte read at vid_addr; valid from phase 3 until the next phase 2 edge
cpu_req  in  1  one-cycle request strobe; ignored when cpu_ready=0
cpu_we  in  1  1=write, 0=read; sampled with cpu_req
cpu_addr  in  ADDR_W  CPU address, sampled with cpu_req
cpu_wdata  in  DATA_W  CPU write data, sampled with cpu_req
cpu_ready  out  1  high when no CPU access is pending (=!busy)
cpu_ack  out  1  one-cycle completion pulse, high in phase 1
cpu_rdata  out  DATA_W  read data, valid while cpu_ack=1 and held until the next ack
mem_addr  out  ADDR_W  RAM address (registered)
mem_we  out  1  RAM write enable (registered)
mem_wdata  out  DATA_W  RAM write data (registered)
mem_rdata  in  DATA_W  RAM read data; synchronous RAM, valid the cycle after the address is presented

Behaviour:
- Reset values: phase=0, busy=0, vid_ce=0, cpu_ready=0 during rst and 1 after, cpu_ack=0, mem_we=0, mem_addr=0, mem_wdata=0, vid_rdata=0, cpu_rdata=0.
- Phase counter: 2 bits, free-running 0→1→2→3→0. vid_ce=(phase==3), registered so it is high exactly during phase 3.
- End of phase 0: mem_addr<=vid_addr, mem_we<=0.
- Phase 1: RAM samples the video address.
- End of phase 2: vid_rdata<=mem_rdata. If busy is already set (latched in an earlier cycle): mem_addr<=cpu_addr_l, mem_we<=cpu_we_l, mem_wdata<=cpu_wdata_l, issued<=1.
- End of phase 3: mem_we<=0.
- End of phase 0, when issued=1: cpu_rdata<=mem_rdata (reads only; a write leaves cpu_rdata unchanged), cpu_ack<=1, busy<=0, issued<=0.
- Accept: at any edge with cpu_req && !busy && !rst, latch we/addr/wdata and set busy. A request accepted at the phase-2 edge itself is not issued in that slot; it waits for the next phase-2 edge.
- Latency: ack goes high 4 (accept in phase 1) to 7 (accept in phase 2) cycles after the accept cycle.
- cpu_ready rises in the same cycle as cpu_ack (phase 1). A new request may be accepted in that cycle.
- Video priority is absolute: the video slot is never delayed or skipped. Video fetch latency is exactly one vid_ce period (address sampled end of phase 0, data visible in phase 3).
- The CPU never observes or corrupts video data. The mem_* lines carry the CPU op only in phase 3.
- At most one CPU access is in flight; there is no queue. cpu_req while cpu_ready=0 is dropped silently (bench-checked).
- Reset mid-operation: a pending or in-flight CPU access is discarded with no ack. mem_we=0 from the reset edge. A write already sampled by the RAM (end of phase 3) is not undone.
- Same-address conflict: a CPU write in frame N is visible to the video read in frame N+1 (no bypass).

Decomposition:
- Shared package vram_pkg: VRAM_ADDR_W=12, VRAM_DATA_W=8, phase constants PH_VID_ADDR=0, PH_VID_RAM=1, PH_CPU_ADDR=2, PH_CPU_RAM=3, TEXT_COLS=80, TEXT_ROWS=25.
- No sub-module required. The phase counter and CPU request latch stay inline.

Test Plan:
- Reset 3 cycles, then run free → vid_ce pulses every 4th cycle starting phase 3. mem_we=0, cpu_ready=1, cpu_ack=0 throughout idle.
- RAM model preloaded with mem[0x0A0]=0x41. Drive vid_addr=0x0A0 on a vid_ce edge → vid_rdata=0x41 in the next phase 3.
- CPU write cpu_req, we=1, addr=0x123, wdata=0x5A, accepted in phase 1 → mem_we=1 only in phase 3 with addr 0x123. cpu_ack 4 cycles after accept. A subsequent video read of 0x123 returns 0x5A.
- CPU read addr=0x7FF (mem=0xC3) accepted in phase 2 → cpu_ack 7 cycles later, cpu_rdata=0xC3. A concurrent video stream at 0x000..0x00F is unaffected.
- Back-to-back: second cpu_req while busy is dropped (no second ack). A request issued in the ack cycle is accepted and acked correctly.
- Assert rst in phase 3 of a pending write to 0x200 → mem_we=0 after the reset edge, no cpu_ack, busy=0, phase restarts at 0.
